// File: rtl/serial_parity_checker.sv
// serial_parity_checker: lock-step multi-lane framed serial parity checker with saturating error count
module serial_parity_checker #(
    parameter int LANES     = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sof,
    input  logic [LANES-1:0] x,
    input  logic             odd_sel,
    output logic [LANES-1:0] running_par,
    output logic             busy,
    output logic             frame_done,
    output logic [LANES-1:0] par_err,
    output logic             frame_abort,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] PAR  = 2'd2;
    localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);
    logic [1:0]       state;
    logic [BW-1:0]    bit_cnt;
    logic             odd_q;
    logic             start;
    logic             beat;
    logic [LANES-1:0] err_next;
    assign start    = in_valid & sof;
    assign beat     = in_valid & ~sof;
    assign busy     = state != IDLE;
    assign err_next = running_par ^ x ^ {LANES{odd_q}};
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            odd_q       <= 1'b0;
            running_par <= '0;
            par_err     <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            err_cnt     <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            // a sof always opens a new frame; mid-frame it discards the old one
            if (start) begin
                running_par <= x;
                odd_q       <= odd_sel;
                bit_cnt     <= BW'(1);
                state       <= (FRAME_LEN == 1) ? PAR : DATA;
                if (busy) begin
                    frame_abort <= 1'b1;
                    par_err     <= '0;
                end
            end else if (beat && state == DATA) begin
                running_par <= running_par ^ x;
                bit_cnt     <= bit_cnt + BW'(1);
                if (bit_cnt == LAST) state <= PAR;
            end else if (beat && state == PAR) begin
                par_err    <= err_next;
                frame_done <= 1'b1;
                bit_cnt    <= '0;
                state      <= IDLE;
                if (|err_next && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: directed checks of the framed parity checker (LANES=2, FRAME_LEN=4, CNT_W=2)
module tb_serial_parity_checker;
    logic       clk = 1'b0;
    logic       rst, in_valid, sof, odd_sel;
    logic [1:0] x, running_par, par_err, err_cnt;
    logic       busy, frame_done, frame_abort;
    int checks = 0;
    int errors = 0;

    serial_parity_checker #(.LANES(2), .FRAME_LEN(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .x(x), .odd_sel(odd_sel),
        .running_par(running_par), .busy(busy), .frame_done(frame_done),
        .par_err(par_err), .frame_abort(frame_abort), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic v, input logic s, input logic [1:0] xv, input logic o);
        @(negedge clk);
        rst = r; in_valid = v; sof = s; x = xv; odd_sel = o;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] rp, input logic b, input logic fd,
                           input logic [1:0] pe, input logic fa, input logic [1:0] ec);
        chk({tag, ".running_par"}, 8'(running_par), 8'(rp));
        chk({tag, ".busy"}, 8'(busy), 8'(b));
        chk({tag, ".frame_done"}, 8'(frame_done), 8'(fd));
        chk({tag, ".par_err"}, 8'(par_err), 8'(pe));
        chk({tag, ".frame_abort"}, 8'(frame_abort), 8'(fa));
        chk({tag, ".err_cnt"}, 8'(err_cnt), 8'(ec));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sof = 1'b0; x = 2'b00; odd_sel = 1'b0;
        step(1, 1, 1, 2'b11, 1);
        step(0, 0, 0, 2'b00, 0);
        chk_all("reset", 2'b00, 0, 0, 2'b00, 0, 2'd0);
        step(0, 1, 0, 2'b11, 0);
        chk_all("idle_nonsof_ignored", 2'b00, 0, 0, 2'b00, 0, 2'd0);

        // test 1: even mode, lane0 1011 p1, lane1 0000 p0
        step(0, 1, 1, 2'b01, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b01, 0);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t1_data", 2'b01, 1, 0, 2'b00, 0, 2'd0);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t1_done", 2'b01, 0, 1, 2'b00, 0, 2'd0);
        step(0, 0, 0, 2'b00, 0);
        chk_all("t1_after", 2'b01, 0, 0, 2'b00, 0, 2'd0);

        // test 2: odd mode latched at sof, odd_sel toggled afterwards
        step(0, 1, 1, 2'b01, 1);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b01, 1);
        step(0, 1, 0, 2'b01, 0);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t2_done", 2'b01, 0, 1, 2'b11, 0, 2'd1);

        // test 3: back-to-back frames, 3-cycle valid gap in frame 2
        step(0, 1, 1, 2'b01, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b01, 0);
        step(0, 1, 0, 2'b01, 0);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t3_f1_done", 2'b01, 0, 1, 2'b00, 0, 2'd1);
        step(0, 1, 1, 2'b11, 0);
        chk_all("t3_f2_sof", 2'b11, 1, 0, 2'b00, 0, 2'd1);
        step(0, 1, 0, 2'b10, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 2'b11, 1);
            chk_all("t3_gap", 2'b01, 1, 0, 2'b00, 0, 2'd1);
        end
        step(0, 1, 0, 2'b01, 0);
        step(0, 1, 0, 2'b00, 0);
        chk_all("t3_f2_beat4", 2'b00, 1, 0, 2'b00, 0, 2'd1);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t3_f2_done", 2'b00, 0, 1, 2'b01, 0, 2'd2);

        // test 4: sof on beat 3 aborts and restarts (odd mode re-sampled)
        step(0, 1, 1, 2'b11, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 1, 2'b10, 1);
        chk_all("t4_abort", 2'b10, 1, 0, 2'b00, 1, 2'd2);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t4_b1", 2'b11, 1, 0, 2'b00, 0, 2'd2);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        chk_all("t4_b3", 2'b11, 1, 0, 2'b00, 0, 2'd2);
        step(0, 1, 0, 2'b00, 0);
        chk_all("t4_done", 2'b11, 0, 1, 2'b00, 0, 2'd2);

        // test 5: fresh reset, 5 errored frames saturate a 2-bit counter
        step(1, 0, 0, 2'b00, 0);
        chk_all("t5_reset", 2'b00, 0, 0, 2'b00, 0, 2'd0);
        for (int f = 0; f < 5; f++) begin
            step(0, 1, 1, 2'b00, 0);
            for (int b = 0; b < 3; b++) step(0, 1, 0, 2'b00, 0);
            step(0, 1, 0, 2'b01, 0);
            chk_all("t5_frame", 2'b00, 0, 1, 2'b01, 0, (f < 3) ? 2'(f + 1) : 2'd3);
        end
        step(0, 1, 1, 2'b01, 0);
        step(0, 1, 0, 2'b01, 0);
        chk_all("t5_midframe", 2'b00, 1, 0, 2'b01, 0, 2'd3);
        step(1, 1, 1, 2'b11, 1);
        chk_all("t5_rst_mid", 2'b00, 0, 0, 2'b00, 0, 2'd0);
        step(0, 1, 0, 2'b11, 0);
        chk_all("t5_post_rst_ignored", 2'b00, 0, 0, 2'b00, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Multi-lane, frame-aware successor to the single-bit serial even/odd parity detector.
- Each lane carries FRAME_LEN serial data bits followed by one parity bit.
- Lanes run in lock-step under a shared valid/start-of-frame strobe.
- Per frame, per lane: running parity is tracked, the received parity bit is checked in even or odd mode, and a per-lane error is reported with a done pulse. A saturating count of errored frames is kept for status readback.

Parameters:
- LANES, 4, number of parallel serial lanes checked in lock-step.
- FRAME_LEN, 8, data bits per frame before the parity bit (>=1).
- CNT_W, 8, width of saturating errored-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  x/sof qualify this cycle; no state advances when low.
- sof  in  1  start of frame; the beat carrying it is data bit 0.
- x  in  LANES  serial bit per lane.
- odd_sel  in  1  0=even parity, 1=odd; sampled only on an accepted sof beat.
- running_par  out  LANES  registered XOR of data bits accepted so far in the current frame.
- busy  out  1  high while in DATA or PAR state.
- frame_done  out  1  one-cycle pulse, cycle after the parity beat is accepted.
- par_err  out  LANES  per-lane error; valid and held from frame_done until the next frame_done or abort.
- frame_abort  out  1  one-cycle pulse when a sof restarts an unfinished frame.
- err_cnt  out  CNT_W  frames with any par_err bit set; saturates at all-ones.

Behaviour:
- Reset (sync, any state, overrides all inputs): state=IDLE; bit_cnt=0; running_par=0; par_err=0; frame_done=0; frame_abort=0; err_cnt=0; odd latch=0. busy is 0 in IDLE.
- bit_cnt width is $clog2(FRAME_LEN+1). All outputs are registered or decoded from state only (Moore); no combinational input-to-output path.
- IDLE:
  - in_valid&sof: running_par<=x, odd latch<=odd_sel, bit_cnt<=1.
  - Next state: PAR if FRAME_LEN==1, else DATA.
  - in_valid without sof is ignored.
- DATA:
  - in_valid&!sof: running_par<=running_par^x, bit_cnt+1.
  - When bit_cnt+1==FRAME_LEN, go to PAR.
- PAR:
  - in_valid&!sof: par_err[i]<=running_par[i]^x[i]^odd_latch; frame_done<=1.
  - err_cnt increments if |par_err_next and err_cnt != all-ones.
  - Next state: IDLE. running_par holds its final value until the next sof.
- sof in DATA or PAR with in_valid: current frame is discarded.
  - frame_abort<=1; par_err<=0; err_cnt unchanged.
  - Beat is taken as bit 0 of a new frame, same as IDLE+sof, including the odd_sel re-sample.
- in_valid low in any state: all state, counters and outputs hold. frame_done and frame_abort return to 0.
- Back-to-back frames: sof is accepted the cycle after the parity beat (state=IDLE). A frame takes a minimum of FRAME_LEN+1 valid beats.
- frame_done and frame_abort are never high in the same cycle.
- Error rules:
  - Even mode: error when total ones across data+parity is odd.
  - Odd mode: error when the total is even.

Test Plan:
1. LANES=2, FRAME_LEN=4, even mode.
   - Stimulus: lane0 data 1,0,1,1 parity 1; lane1 data 0,0,0,0 parity 0.
   - Required: running_par=2'b01 after data; frame_done once; par_err=00; err_cnt=0.
2. Same data as test 1, odd_sel=1 at sof.
   - Required: par_err=11; err_cnt=1.
   - Flip odd_sel mid-frame: no effect on the result.
3. Two frames back-to-back; in_valid deasserted for 3 cycles inside frame 2.
   - Required: state and running_par hold during the gap.
   - Frame 2 done exactly after its 5th valid beat.
4. sof asserted on beat 3 of a frame.
   - Required: frame_abort pulse; par_err cleared; new frame completes 5 valid beats after that sof.
5. CNT_W=2: drive 5 errored frames.
   - Required: err_cnt 1,2,3,3,3.
   - rst asserted mid-frame: all outputs 0 and state IDLE the next cycle.
   - A non-sof valid beat after reset is ignored.
